// File: rtl/lsu_store_queue.sv
// LSU store queue: program-ordered stores, in-order commit, flush of speculative
// entries, dcache drain and age-checked byte-granular store-to-load forwarding.
module lsu_store_queue #(
    parameter int NR_ENTRIES = 8,
    parameter int XLEN       = 64,
    parameter int PADDR_W    = 64,
    parameter int ID_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [ID_W-1:0]               push_id,
    input  logic [PADDR_W-1:0]            push_paddr,
    input  logic [XLEN-1:0]               push_wdata,
    input  logic [XLEN/8-1:0]             push_wmask,
    input  logic                          commit_valid,
    input  logic                          flush_valid,
    output logic                          dc_wvalid,
    input  logic                          dc_wready,
    output logic [PADDR_W-1:0]            dc_waddr,
    output logic [XLEN-1:0]               dc_wdata,
    output logic [XLEN/8-1:0]             dc_wmask,
    input  logic                          fwd_valid,
    input  logic [ID_W-1:0]               fwd_id,
    input  logic [PADDR_W-1:0]            fwd_paddr,
    input  logic [XLEN/8-1:0]             fwd_lmask,
    output logic [XLEN/8-1:0]             fwd_mask,
    output logic [XLEN-1:0]               fwd_data,
    output logic                          fwd_full,
    output logic                          empty,
    output logic [$clog2(NR_ENTRIES):0]   count,
    output logic                          err
);
    localparam int IW  = $clog2(NR_ENTRIES);
    localparam int PW  = IW + 1;
    localparam int MW  = XLEN / 8;
    localparam int OFF = $clog2(MW);

    logic [PW-1:0]      head_q, cmt_q, tail_q;
    logic [PW-1:0]      cnt, cmt_d, tail_d;
    logic [ID_W-1:0]    id_q   [NR_ENTRIES];
    logic [PADDR_W-1:0] addr_q [NR_ENTRIES];
    logic [XLEN-1:0]    data_q [NR_ENTRIES];
    logic [MW-1:0]      mask_q [NR_ENTRIES];
    logic [IW-1:0]      hidx;
    logic               full, push_fire, commit_ok, pop;

    assign cnt        = tail_q - head_q;
    assign full       = (cnt == PW'(NR_ENTRIES));
    assign push_ready = !full;
    assign empty      = (cnt == '0);
    assign count      = cnt;
    assign hidx       = head_q[IW-1:0];

    // Entries in [head, cmt) are committed; only those may drain.
    assign dc_wvalid  = (head_q != cmt_q);
    assign dc_waddr   = dc_wvalid ? addr_q[hidx] : '0;
    assign dc_wdata   = dc_wvalid ? data_q[hidx] : '0;
    assign dc_wmask   = dc_wvalid ? mask_q[hidx] : '0;
    assign pop        = dc_wvalid & dc_wready;

    assign commit_ok  = commit_valid & (cmt_q != tail_q);
    assign push_fire  = push_valid & push_ready & !flush_valid;
    assign cmt_d      = cmt_q + PW'(commit_ok);
    // Flush lands after the same-cycle commit, so the committing entry survives.
    assign tail_d     = flush_valid ? cmt_d : tail_q + PW'(push_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            err    <= 1'b0;
        end else begin
            head_q <= head_q + PW'(pop);
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            err    <= err | (commit_valid & !commit_ok)
                          | (push_valid & full & !flush_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            id_q[tail_q[IW-1:0]]   <= push_id;
            addr_q[tail_q[IW-1:0]] <= push_paddr;
            data_q[tail_q[IW-1:0]] <= push_wdata;
            mask_q[tail_q[IW-1:0]] <= push_wmask;
        end
    end

    logic [IW-1:0]   fidx;
    logic [ID_W-1:0] fdiff;
    logic            fhit;

    // Oldest to youngest with overwrite: the youngest older store wins per byte.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        fidx     = '0;
        fdiff    = '0;
        fhit     = 1'b0;
        for (int k = 0; k < NR_ENTRIES; k++) begin
            fidx  = hidx + IW'(k);
            fdiff = fwd_id - id_q[fidx];
            fhit  = fwd_valid && (PW'(k) < cnt)
                    && (addr_q[fidx][PADDR_W-1:OFF] == fwd_paddr[PADDR_W-1:OFF])
                    && !fdiff[ID_W-1] && (fdiff != '0);
            for (int b = 0; b < MW; b++) begin
                if (fhit && mask_q[fidx][b] && fwd_lmask[b]) begin
                    fwd_mask[b]        = 1'b1;
                    fwd_data[8*b +: 8] = data_q[fidx][8*b +: 8];
                end
            end
        end
    end

    assign fwd_full = fwd_valid & (fwd_mask == fwd_lmask) & (|fwd_lmask);

    logic unused_lo;
    assign unused_lo = ^fwd_paddr[OFF-1:0];
endmodule

// File: tb/tb_lsu_store_queue.sv
// Self-checking bench for lsu_store_queue: directed scenarios plus randomized
// traffic compared each cycle against a queue-based reference model.
module tb_lsu_store_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid, push_ready;
    logic [7:0]  push_id;
    logic [63:0] push_paddr, push_wdata;
    logic [7:0]  push_wmask;
    logic        commit_valid, flush_valid;
    logic        dc_wvalid, dc_wready;
    logic [63:0] dc_waddr, dc_wdata;
    logic [7:0]  dc_wmask;
    logic        fwd_valid;
    logic [7:0]  fwd_id;
    logic [63:0] fwd_paddr;
    logic [7:0]  fwd_lmask, fwd_mask;
    logic [63:0] fwd_data;
    logic        fwd_full, empty, err;
    logic [3:0]  count;

    lsu_store_queue dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_id(push_id), .push_paddr(push_paddr),
        .push_wdata(push_wdata), .push_wmask(push_wmask),
        .commit_valid(commit_valid), .flush_valid(flush_valid),
        .dc_wvalid(dc_wvalid), .dc_wready(dc_wready),
        .dc_waddr(dc_waddr), .dc_wdata(dc_wdata), .dc_wmask(dc_wmask),
        .fwd_valid(fwd_valid), .fwd_id(fwd_id), .fwd_paddr(fwd_paddr),
        .fwd_lmask(fwd_lmask), .fwd_mask(fwd_mask), .fwd_data(fwd_data),
        .fwd_full(fwd_full), .empty(empty), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  id;
        logic [63:0] paddr;
        logic [63:0] data;
        logic [7:0]  mask;
    } ent_t;

    ent_t       q[$];
    int         ncmt = 0;
    bit         merr = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] nid = 8'd0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fwd_ref(output logic [7:0] m, output logic [63:0] d);
        logic [7:0] diff;
        m = '0;
        d = '0;
        if (fwd_valid) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                diff = fwd_id - q[i].id;
                if ((q[i].paddr >> 3) == (fwd_paddr >> 3) && $signed(diff) > 0) begin
                    for (int b = 0; b < 8; b++) begin
                        if (!m[b] && q[i].mask[b] && fwd_lmask[b]) begin
                            m[b] = 1'b1;
                            d[8*b +: 8] = q[i].data[8*b +: 8];
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all(string t);
        logic [7:0]  em;
        logic [63:0] ed, ea, ew;
        logic [7:0]  emk;
        bit          wv;
        fwd_ref(em, ed);
        wv  = ncmt > 0;
        ea  = '0;
        ew  = '0;
        emk = '0;
        if (wv) begin
            ea  = q[0].paddr;
            ew  = q[0].data;
            emk = q[0].mask;
        end
        chk({t, ".count"}, 64'(count), 64'(q.size()));
        chk({t, ".ready"}, 64'(push_ready), 64'(q.size() < 8));
        chk({t, ".empty"}, 64'(empty), 64'(q.size() == 0));
        chk({t, ".err"}, 64'(err), 64'(merr));
        chk({t, ".wvalid"}, 64'(dc_wvalid), 64'(wv));
        chk({t, ".waddr"}, dc_waddr, ea);
        chk({t, ".wdata"}, dc_wdata, ew);
        chk({t, ".wmask"}, 64'(dc_wmask), 64'(emk));
        chk({t, ".fmask"}, 64'(fwd_mask), 64'(em));
        chk({t, ".fdata"}, fwd_data, ed);
        chk({t, ".ffull"}, 64'(fwd_full),
            64'(fwd_valid && em == fwd_lmask && fwd_lmask != 0));
    endtask

    task automatic model_step;
        bit full, pop, cok;
        ent_t e;
        full = q.size() == 8;
        pop  = ncmt > 0 && dc_wready;
        cok  = commit_valid && ncmt < q.size();
        if (commit_valid && !cok) merr = 1;
        if (push_valid && full && !flush_valid) merr = 1;
        if (cok) ncmt++;
        if (flush_valid) begin
            while (q.size() > ncmt) void'(q.pop_back());
        end else if (push_valid && !full) begin
            e.id = push_id;
            e.paddr = push_paddr;
            e.data = push_wdata;
            e.mask = push_wmask;
            q.push_back(e);
        end
        if (pop) begin
            void'(q.pop_front());
            ncmt--;
        end
    endtask

    task automatic cyc(string t);
        #1;
        check_all(t);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle;
        push_valid   = 0;
        push_id      = '0;
        push_paddr   = '0;
        push_wdata   = '0;
        push_wmask   = '0;
        commit_valid = 0;
        flush_valid  = 0;
        fwd_valid    = 0;
        fwd_id       = '0;
        fwd_paddr    = '0;
        fwd_lmask    = '0;
    endtask

    task automatic push(logic [7:0] id, logic [63:0] a,
                        logic [63:0] d, logic [7:0] m);
        push_valid = 1;
        push_id    = id;
        push_paddr = a;
        push_wdata = d;
        push_wmask = m;
    endtask

    logic [63:0] sv_addr, sv_data;
    bit          stall_prev;

    initial begin
        rst = 1;
        dc_wready = 0;
        idle();
        #12;
        check_all("reset");
        rst = 0;

        // single store end to end
        dc_wready = 1;
        push(8'd1, 64'h1000, 64'h1122334455667788, 8'hFF);
        cyc("t1push");
        push_valid = 0;
        commit_valid = 1;
        cyc("t1cmt");
        commit_valid = 0;
        #1;
        chk("t1_wvalid", 64'(dc_wvalid), 64'd1);
        chk("t1_waddr", dc_waddr, 64'h1000);
        cyc("t1pop");
        #1;
        chk("t1_empty", 64'(empty), 64'd1);

        // forwarding with age check
        push(8'd3, 64'h2000, 64'hAABBCCDD, 8'h0F);
        cyc("fw3");
        push(8'd5, 64'h2000, 64'h1122, 8'h03);
        cyc("fw5");
        push_valid = 0;
        fwd_valid = 1;
        fwd_paddr = 64'h2000;
        fwd_lmask = 8'h0F;
        fwd_id = 8'd7;
        #1;
        chk("fw7_mask", 64'(fwd_mask), 64'h0F);
        chk("fw7_data", fwd_data, 64'hAABB1122);
        chk("fw7_full", 64'(fwd_full), 64'd1);
        fwd_id = 8'd4;
        #1;
        chk("fw4_mask", 64'(fwd_mask), 64'h0F);
        chk("fw4_data", fwd_data, 64'hAABBCCDD);
        fwd_id = 8'd3;
        #1;
        chk("fw3_mask", 64'(fwd_mask), 64'h00);
        chk("fw3_data", fwd_data, 64'h0);
        cyc("fwlook");
        fwd_valid = 0;
        flush_valid = 1;
        cyc("fwflush");
        flush_valid = 0;
        #1;
        chk("fw_cleared", 64'(count), 64'd0);

        // commit + flush in one cycle
        for (int i = 1; i <= 3; i++) begin
            push(8'(i), 64'(i * 16), 64'(i * 64'h0101), 8'hFF);
            cyc("cfpush");
        end
        push_valid = 0;
        commit_valid = 1;
        cyc("cfc1");
        flush_valid = 1;
        #1;
        chk("cf_head1", dc_waddr, 64'h10);
        cyc("cfboth");
        commit_valid = 0;
        flush_valid = 0;
        #1;
        chk("cf_head2", dc_waddr, 64'h20);
        chk("cf_cnt1", 64'(count), 64'd1);
        cyc("cfdrain");
        #1;
        chk("cf_cnt0", 64'(count), 64'd0);
        chk("cf_wv0", 64'(dc_wvalid), 64'd0);

        // fill to full, overflow sets err
        dc_wready = 0;
        for (int i = 1; i <= 8; i++) begin
            push(8'(i), 64'h4000 + 64'(i * 8), 64'(i), 8'h01);
            cyc("fill");
        end
        push_valid = 0;
        #1;
        chk("full_ready", 64'(push_ready), 64'd0);
        push(8'd9, 64'h5000, 64'h9, 8'h01);
        cyc("ovf");
        push_valid = 0;
        #1;
        chk("ovf_err", 64'(err), 64'd1);
        commit_valid = 1;
        cyc("fcmt");
        commit_valid = 0;
        dc_wready = 1;
        cyc("fdrain");
        dc_wready = 0;
        #1;
        chk("refill_ready", 64'(push_ready), 64'd1);
        chk("refill_cnt", 64'(count), 64'd7);
        flush_valid = 1;
        cyc("fflush");
        flush_valid = 0;

        // randomized traffic, dc_wready toggling
        nid = 8'd20;
        stall_prev = 0;
        for (int n = 0; n < 80; n++) begin
            idle();
            dc_wready = n[0];
            if ($urandom_range(0, 1) == 1) begin
                push(nid, 64'h3000 + 64'($urandom_range(0, 1) * 8)
                          + 64'($urandom_range(0, 7)),
                     {$urandom, $urandom}, 8'($urandom));
                nid = nid + 8'd1;
            end
            commit_valid = ($urandom_range(0, 1) == 1) && (ncmt < q.size());
            flush_valid = ($urandom_range(0, 11) == 0);
            fwd_valid = ($urandom_range(0, 3) != 0);
            fwd_id = 8'(nid - 8'($urandom_range(0, 5)));
            fwd_paddr = 64'h3000 + 64'($urandom_range(0, 1) * 8);
            fwd_lmask = 8'($urandom);
            #1;
            if (stall_prev) begin
                chk("stall_addr", dc_waddr, sv_addr);
                chk("stall_data", dc_wdata, sv_data);
            end
            stall_prev = dc_wvalid && !dc_wready;
            sv_addr = dc_waddr;
            sv_data = dc_wdata;
            cyc("rnd");
        end
        idle();

        // empty out, then reset in the middle of a drain
        flush_valid = 1;
        cyc("pflush");
        flush_valid = 0;
        dc_wready = 1;
        for (int n = 0; n < 12 && q.size() > 0; n++) cyc("pdrain");
        chk("pre_empty", 64'(count), 64'd0);
        dc_wready = 0;
        for (int i = 0; i < 3; i++) begin
            push(8'(nid + 8'(i)), 64'h6000 + 64'(i * 8), 64'(i + 7), 8'hFF);
            cyc("rpush");
        end
        push_valid = 0;
        commit_valid = 1;
        repeat (3) cyc("rcmt");
        commit_valid = 0;
        dc_wready = 1;
        #1;
        chk("r_wv", 64'(dc_wvalid), 64'd1);
        #2;
        rst = 1;
        #1;
        q.delete();
        ncmt = 0;
        merr = 0;
        chk("r_cnt", 64'(count), 64'd0);
        chk("r_wv0", 64'(dc_wvalid), 64'd0);
        chk("r_err", 64'(err), 64'd0);
        check_all("rmid");
        @(posedge clk);
        #1;
        rst = 0;
        repeat (3) begin
            cyc("post");
            chk("post_wv", 64'(dc_wvalid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
